mem_access: RTL

- Pipeline stage 4 (MEM) of the 5-stage RV32I core. Sits between the EX/MEM latch and writeback, and drives the MEM/WB latch that writeback consumes.
- Performs loads and stores over a level-handshake data-memory bus. Aligns and sign-extends load data, replicates store data with byte enables, and passes ALU results through for non-memory instructions.
- Stalls upstream while a bus transaction is outstanding. Flags misaligned accesses and bus timeouts.

---
 rtl/mem_access_pkg.sv | 40 ++++
 rtl/mem_access_if.sv | 22 ++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_access.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants, types and decode helpers for the MEM stage of the RV32I core.
package mem_access_pkg;

  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;

  localparam logic [2:0]  F3_B  = 3'b000;
  localparam logic [2:0]  F3_H  = 3'b001;
  localparam logic [2:0]  F3_W  = 3'b010;
  localparam logic [2:0]  F3_BU = 3'b100;
  localparam logic [2:0]  F3_HU = 3'b101;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  // Unrecognised funct3 encodings fall back to a full-word access.
  function automatic access_size_e size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      F3_W:        return SZ_WORD;
      default:     return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Level-handshake data-memory bus between the MEM stage (master) and data memory (slave).
interface mem_access_if;

  logic        DREQ;
  logic        DWR;
  logic [31:0] DADDR;
  logic [31:0] DWDATA;
  logic [3:0]  DBE;
  logic        DACK;
  logic [31:0] DRDATA;

  modport master (
    output DREQ, DWR, DADDR, DWDATA, DBE,
    input  DACK, DRDATA
  );

  modport slave (
    input  DREQ, DWR, DADDR, DWDATA, DBE,
    output DACK, DRDATA
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for loads and stores: store replication and byte enables,
// load extraction with sign/zero extension, and misalignment detection.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data,
  output logic        misaligned
);

  access_size_e size;
  logic         sign;
  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    size       = size_of(funct3);
    sign       = (funct3 == F3_B) || (funct3 == F3_H);
    wdata      = rs2;
    be         = 4'b1111;
    load_data  = rdata;
    misaligned = 1'b0;

    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign & byte_sel[7]}}, byte_sel};
        wdata     = {4{rs2[7:0]}};
        be        = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        load_data  = {{16{sign & half_sel[15]}}, half_sel};
        wdata      = {2{rs2[15:0]}};
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: issues loads/stores on the data bus, stalls upstream while a transaction
// is outstanding, and fills the MEM/WB latch with results or bubbles.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP_INST = NOP_WORD
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        HLT,
  input  logic        EX_MEM_valid,
  input  logic [31:0] EX_MEM_pc,
  input  logic [31:0] EX_MEM_inst,
  input  logic [31:0] EX_MEM_alu,
  input  logic [31:0] EX_MEM_rs2,
  input  logic [4:0]  EX_MEM_rd,
  output logic        MEM_STALL,
  output logic        MEM_FAULT,
  output logic        MEM_WB_valid,
  output logic [31:0] MEM_WB_pc,
  output logic [31:0] MEM_WB_inst,
  output logic [31:0] MEM_WB_alu,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] MEM_WB_data,
  mem_access_if.master bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [0:0]  state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        fault_nxt;
  logic        req_nxt;
  logic        issue;
  wb_t         wb_q, wb_nxt, wb_pass;

  logic [2:0]  funct3;
  logic        is_load, is_store, mem_op;
  logic [31:0] wdata, load_data;
  logic [3:0]  be;
  logic        misaligned;

  assign funct3   = EX_MEM_inst[14:12];
  assign is_load  = EX_MEM_inst[6:0] == OPC_LOAD;
  assign is_store = EX_MEM_inst[6:0] == OPC_STORE;
  assign mem_op   = EX_MEM_valid && (is_load || is_store);

  mem_lane_align u_lane_align (
    .funct3     (funct3),
    .addr_lo    (EX_MEM_alu[1:0]),
    .rs2        (EX_MEM_rs2),
    .rdata      (bus.DRDATA),
    .wdata      (wdata),
    .be         (be),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  // In WAIT the stall drops as soon as DACK is seen, so upstream advances on the
  // same edge that captures the result.
  assign MEM_STALL = (state == S_IDLE) ? (mem_op && !misaligned) : !bus.DACK;

  always_comb begin
    wb_pass = '{valid: 1'b1, pc: EX_MEM_pc, inst: EX_MEM_inst, alu: EX_MEM_alu,
                rd: EX_MEM_rd, data: EX_MEM_alu};
    wb_nxt  = '{valid: 1'b0, pc: EX_MEM_pc, inst: NOP_INST, alu: EX_MEM_alu,
                rd: 5'd0, data: 32'd0};
    state_nxt = state;
    cnt_nxt   = cnt;
    fault_nxt = 1'b0;
    req_nxt   = bus.DREQ;
    issue     = 1'b0;

    case (state)
      S_IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            fault_nxt = 1'b1;
          end else begin
            issue     = 1'b1;
            req_nxt   = 1'b1;
            cnt_nxt   = 8'd0;
            state_nxt = S_WAIT;
          end
        end else if (EX_MEM_valid) begin
          wb_nxt = wb_pass;
        end
      end
      S_WAIT: begin
        if (bus.DACK) begin
          wb_nxt      = wb_pass;
          wb_nxt.data = is_load ? load_data : 32'd0;
          req_nxt     = 1'b0;
          state_nxt   = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          fault_nxt = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      MEM_FAULT  <= 1'b0;
      wb_q       <= '{valid: 1'b0, pc: 32'd0, inst: NOP_INST, alu: 32'd0, rd: 5'd0, data: 32'd0};
      bus.DREQ   <= 1'b0;
      bus.DWR    <= 1'b0;
      bus.DADDR  <= 32'd0;
      bus.DBE    <= 4'd0;
      bus.DWDATA <= 32'd0;
    end else if (!HLT) begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      MEM_FAULT <= fault_nxt;
      wb_q      <= wb_nxt;
      bus.DREQ  <= req_nxt;
      if (issue) begin
        bus.DWR    <= is_store;
        bus.DADDR  <= {EX_MEM_alu[31:2], 2'b00};
        bus.DBE    <= is_store ? be : 4'b0000;
        bus.DWDATA <= is_store ? wdata : 32'd0;
      end
    end
  end

  assign MEM_WB_valid = wb_q.valid;
  assign MEM_WB_pc    = wb_q.pc;
  assign MEM_WB_inst  = wb_q.inst;
  assign MEM_WB_alu   = wb_q.alu;
  assign MEM_WB_rd    = wb_q.rd;
  assign MEM_WB_data  = wb_q.data;

endmodule
